// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX stage ALU with an iterative 32-step shift-add multiplier,
// feeding the EX/MEM pipeline register.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            squash the current EX instruction (loads a bubble)
//   val1_i, val2_i     ALU operands
//   ALUCtrl_i          0010 add, 0110 sub, 0000 and, 0001 or, 0011 mul
//   store_data_i, rd_addr_i, Mem_i, WB_i   control/data passed to MEM
//   alu_result_o, zero_o                   registered result and (result == 0)
//   store_data_o, rd_addr_o, Mem_o, WB_o   registered copies of the inputs
//   stall_o            combinational; upstream holds its inputs while high
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | single-cycle ops complete here; a mul starts from here
// MUL_BUSY | one shift-add step per edge, step_cnt = steps already done
module ex_mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] val1_i,
    input  logic [31:0] val2_i,
    input  logic [3:0]  ALUCtrl_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [1:0]  Mem_i,
    input  logic        WB_i,
    output logic [31:0] alu_result_o,
    output logic        zero_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_addr_o,
    output logic [1:0]  Mem_o,
    output logic        WB_o,
    output logic        stall_o
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0011;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t      state;
    logic [4:0]  step_cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;

    logic [31:0] alu_res;
    logic [31:0] acc_next;
    logic        is_mul;

    assign is_mul = (ALUCtrl_i == OP_MUL);

    always_comb begin
        alu_res = 32'd0;
        case (ALUCtrl_i)
            OP_ADD:  alu_res = val1_i + val2_i;
            OP_SUB:  alu_res = val1_i - val2_i;
            OP_AND:  alu_res = val1_i & val2_i;
            OP_OR:   alu_res = val1_i | val2_i;
            default: alu_res = 32'd0;
        endcase
    end

    // Accumulator value after this step; on the last step it is the product.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Flush and reset both end any mul this cycle, so the stall drops with them.
    assign stall_o = !rst_i && !flush_i &&
                     ((state == MUL_BUSY) || (state == IDLE && is_mul));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            step_cnt     <= 5'd0;
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            acc          <= 32'd0;
            alu_result_o <= 32'd0;
            zero_o       <= 1'b0;
            store_data_o <= 32'd0;
            rd_addr_o    <= 5'd0;
            Mem_o        <= 2'b00;
            WB_o         <= 1'b0;
        end else if (flush_i) begin
            state        <= IDLE;
            step_cnt     <= 5'd0;
            alu_result_o <= 32'd0;
            zero_o       <= 1'b0;
            store_data_o <= 32'd0;
            rd_addr_o    <= 5'd0;
            Mem_o        <= 2'b00;
            WB_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        mcand        <= val1_i;
                        mplier       <= val2_i;
                        acc          <= 32'd0;
                        step_cnt     <= 5'd0;
                        state        <= MUL_BUSY;
                        alu_result_o <= 32'd0;
                        zero_o       <= 1'b0;
                        store_data_o <= 32'd0;
                        rd_addr_o    <= 5'd0;
                        Mem_o        <= 2'b00;
                        WB_o         <= 1'b0;
                    end else begin
                        alu_result_o <= alu_res;
                        zero_o       <= (alu_res == 32'd0);
                        store_data_o <= store_data_i;
                        rd_addr_o    <= rd_addr_i;
                        Mem_o        <= Mem_i;
                        WB_o         <= WB_i;
                    end
                end
                MUL_BUSY: begin
                    acc      <= acc_next;
                    mcand    <= {mcand[30:0], 1'b0};
                    mplier   <= {1'b0, mplier[31:1]};
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == 5'd31) begin
                        // Control fields come from the inputs upstream held
                        // for the whole stall.
                        state        <= IDLE;
                        step_cnt     <= 5'd0;
                        alu_result_o <= acc_next;
                        zero_o       <= (acc_next == 32'd0);
                        store_data_o <= store_data_i;
                        rd_addr_o    <= rd_addr_i;
                        Mem_o        <= Mem_i;
                        WB_o         <= WB_i;
                    end else begin
                        alu_result_o <= 32'd0;
                        zero_o       <= 1'b0;
                        store_data_o <= 32'd0;
                        rd_addr_o    <= 5'd0;
                        Mem_o        <= 2'b00;
                        WB_o         <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    step_cnt <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_i, flush_i;
    logic [31:0] val1_i, val2_i, store_data_i;
    logic [3:0]  ALUCtrl_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  Mem_i;
    logic        WB_i;
    logic [31:0] alu_result_o, store_data_o;
    logic        zero_o, WB_o, stall_o;
    logic [4:0]  rd_addr_o;
    logic [1:0]  Mem_o;

    ex_mem_stage dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .val1_i(val1_i), .val2_i(val2_i), .ALUCtrl_i(ALUCtrl_i),
        .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .Mem_i(Mem_i), .WB_i(WB_i),
        .alu_result_o(alu_result_o), .zero_o(zero_o),
        .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
        .Mem_o(Mem_o), .WB_o(WB_o), .stall_o(stall_o)
    );

    // Clock starts high so the first falling edge samples cycle 0.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        chk_out;
        logic        stall;
        logic [31:0] res;
        logic        zero;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [1:0]  mem;
        logic        wb;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a mul is a plain 32-bit product delivered 33 cycles
    // after it is presented; everything else finishes after one edge.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_prod = 32'd0;
    exp_t        prev_out;
    logic        have_prev = 1'b0;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'b0010) return a + b;
        if (op == 4'b0110) return a - b;
        if (op == 4'b0000) return a & b;
        if (op == 4'b0001) return a | b;
        return 32'd0;
    endfunction

    task automatic cyc(input logic r, input logic f, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                       input logic [4:0] rd, input logic [1:0] mem, input logic wb);
        exp_t e;
        exp_t nxt;
        rst_i = r; flush_i = f; ALUCtrl_i = op; val1_i = a; val2_i = b;
        store_data_i = sd; rd_addr_i = rd; Mem_i = mem; WB_i = wb;
        e = prev_out;
        e.chk_out = have_prev;
        e.stall = !r && !f && (m_busy || op == 4'b0011);
        nxt = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 2'b00, 1'b0};
        if (r || f) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy = 1'b0;
                nxt.res = m_prod; nxt.zero = (m_prod == 32'd0);
                nxt.sd = sd; nxt.rd = rd; nxt.mem = mem; nxt.wb = wb;
            end else begin
                m_left--;
            end
        end else if (op == 4'b0011) begin
            m_busy = 1'b1;
            m_left = 32;
            m_prod = a * b;
        end else begin
            nxt.res = ref_alu(op, a, b); nxt.zero = (nxt.res == 32'd0);
            nxt.sd = sd; nxt.rd = rd; nxt.mem = mem; nxt.wb = wb;
        end
        q.push_back(e);
        prev_out = nxt;
        have_prev = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: every falling edge consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
                if (e.chk_out) begin
                    chk("alu_result_o", alu_result_o, e.res);
                    chk("zero_o", {31'd0, zero_o}, {31'd0, e.zero});
                    chk("store_data_o", store_data_o, e.sd);
                    chk("rd_addr_o", {27'd0, rd_addr_o}, {27'd0, e.rd});
                    chk("Mem_o", {30'd0, Mem_o}, {30'd0, e.mem});
                    chk("WB_o", {31'd0, WB_o}, {31'd0, e.wb});
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [3:0]  h_op;
    logic [31:0] h_a, h_b, h_sd;
    logic [4:0]  h_rd;
    logic [1:0]  h_mem;
    logic        h_wb;

    initial begin
        cyc(1, 0, 4'b0010, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);
        cyc(1, 0, 4'b0011, 32'd1, 32'd1, 32'd1, 5'd1, 2'b01, 1'b1);

        // add, sub wrap, sub to zero
        cyc(0, 0, 4'b0010, 32'd5, 32'd7, 32'h11, 5'd3, 2'b00, 1'b1);
        cyc(0, 0, 4'b0110, 32'd0, 32'd1, 32'h22, 5'd4, 2'b10, 1'b1);
        cyc(0, 0, 4'b0110, 32'd9, 32'd9, 32'h33, 5'd5, 2'b01, 1'b0);
        cyc(0, 0, 4'b1111, 32'd9, 32'd2, 32'h44, 5'd6, 2'b11, 1'b1);

        // mul held for its whole 33-cycle stall
        repeat (33) cyc(0, 0, 4'b0011, 32'h0000FFFF, 32'h00010001, 32'h55, 5'd7, 2'b00, 1'b1);
        repeat (33) cyc(0, 0, 4'b0011, 32'hFFFFFFFF, 32'd3, 32'h66, 5'd8, 2'b10, 1'b1);
        cyc(0, 0, 4'b0001, 32'hF0, 32'h0F, 32'd0, 5'd9, 2'b00, 1'b1);

        // flush at step 10, then a single-cycle and
        repeat (11) cyc(0, 0, 4'b0011, 32'd123, 32'd456, 32'h77, 5'd10, 2'b01, 1'b1);
        cyc(0, 1, 4'b0011, 32'd123, 32'd456, 32'h77, 5'd10, 2'b01, 1'b1);
        cyc(0, 0, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h88, 5'd11, 2'b00, 1'b1);

        // reset at step 20; the aborted product must never appear
        repeat (21) cyc(0, 0, 4'b0011, 32'd1000, 32'd1000, 32'h99, 5'd12, 2'b00, 1'b1);
        cyc(1, 0, 4'b0011, 32'd1000, 32'd1000, 32'h99, 5'd12, 2'b00, 1'b1);
        repeat (15) cyc(0, 0, 4'b0001, 32'd0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0);

        // randomized traffic; inputs held while the model says the stage is busy
        h_op = 4'b0010; h_a = 0; h_b = 0; h_sd = 0; h_rd = 0; h_mem = 0; h_wb = 0;
        for (int i = 0; i < 2000; i++) begin
            logic rr, ff;
            if (!m_busy) begin
                case ($urandom_range(0, 9))
                    0, 1:    h_op = 4'b0010;
                    2, 3:    h_op = 4'b0110;
                    4:       h_op = 4'b0000;
                    5:       h_op = 4'b0001;
                    6, 9:    h_op = 4'b0011;
                    default: h_op = 4'($urandom);
                endcase
                h_a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                h_b   = ($urandom_range(0, 3) == 0) ? h_a : $urandom;
                h_sd  = $urandom;
                h_rd  = 5'($urandom);
                h_mem = 2'($urandom);
                h_wb  = 1'($urandom);
            end
            rr = ($urandom_range(0, 199) == 0);
            ff = ($urandom_range(0, 39) == 0);
            cyc(rr, ff, h_op, h_a, h_b, h_sd, h_rd, h_mem, h_wb);
        end
        cyc(0, 0, 4'b0010, 32'd1, 32'd1, 32'd0, 5'd0, 2'b00, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #2;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port flush_i, input, 1 bit: squash the current EX instruction.
REQ-004 SHALL have ports val1_i and val2_i, input, 32 bits each: ALU operands from the ID/EX stage.
REQ-005 SHALL have port ALUCtrl_i, input, 4 bits: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 mul (low 32 bits of the product).
REQ-006 SHALL have port store_data_i, input, 32 bits: rs2 data for stores.
REQ-007 SHALL have port rd_addr_i, input, 5 bits: destination register.
REQ-008 SHALL have port Mem_i, input, 2 bits: memory control.
REQ-009 SHALL have port WB_i, input, 1 bit: writeback enable.
REQ-010 SHALL have port alu_result_o, output, 32 bits: registered result.
REQ-011 SHALL have port zero_o, output, 1 bit: registered flag, (result == 0).
REQ-012 SHALL have ports store_data_o (32 bits), rd_addr_o (5 bits), Mem_o (2 bits) and WB_o (1 bit), outputs: registered copies of the corresponding inputs.
REQ-013 SHALL have port stall_o, output, 1 bit, combinational: the upstream stage must hold all inputs while it is high.

Function
REQ-014 SHALL implement an FSM with states IDLE and MUL_BUSY, plus a 5-bit step counter, a 32-bit multiplicand register, a 32-bit multiplier register and a 32-bit accumulator.
REQ-015 SHALL, in IDLE when ALUCtrl_i is not 0011 and flush_i=0, load on the next edge:
- alu_result_o with the operation result, wrapping mod 2^32;
- zero_o with (result == 0);
- store_data_o, rd_addr_o, Mem_o and WB_o from the inputs.
This gives 1-cycle latency.
REQ-016 SHALL, for any ALUCtrl_i value not listed, load alu_result_o=0 and zero_o=1 while passing the control fields unchanged.
REQ-017 SHALL, in IDLE when ALUCtrl_i=0011 and flush_i=0, assert stall_o, latch the operands, clear the accumulator and counter, load a bubble, and move to MUL_BUSY on the edge.
REQ-018 SHALL, in MUL_BUSY, perform one shift-add step per edge:
- add the multiplicand to the accumulator if multiplier bit 0 is 1;
- shift the multiplicand left by 1 and the multiplier right by 1;
- increment the counter.
REQ-019 SHALL keep stall_o high throughout MUL_BUSY.
REQ-020 SHALL, on the MUL_BUSY edge where counter=31, load alu_result_o with the final product, load zero_o and the control fields from the held inputs, and return to IDLE; stall_o is low in the following cycle.
REQ-021 SHALL, for each MUL_BUSY edge with counter<31, load a bubble into the output register.
REQ-022 SHALL define a bubble as WB_o=0, Mem_o=00, rd_addr_o=0, alu_result_o=0, store_data_o=0 and zero_o=0.
REQ-023 SHALL give a mul presented in cycle 0 the following timing: stall_o high in cycles 0..32, result visible from cycle 33, 33 cycles in total.
REQ-024 SHALL, when flush_i=1, load a bubble on the edge and force IDLE with the counter cleared, in any state.
REQ-025 SHALL give flush_i priority over starting a new mul and over completing an in-flight mul.
REQ-026 SHALL drive stall_o low in any cycle where flush_i=1.
REQ-027 SHALL compute mul identically for signed and unsigned operands, since only the low 32 bits are produced.
REQ-028 SHALL treat back-to-back mul instructions independently: a second mul arriving in the cycle after completion starts a fresh 33-cycle sequence.

Reset
REQ-029 SHALL, on an edge with rst_i=1, set state=IDLE, counter=0, all datapath registers to 0, and all registered outputs to 0.
REQ-030 SHALL drive stall_o=0 during reset.
REQ-031 SHALL give rst_i priority over flush_i and all other inputs.
REQ-032 SHALL, when rst_i is asserted during MUL_BUSY, abort the operation so that no result is ever written.

Verification
REQ-033 SHALL cover add: val1=5, val2=7, ALUCtrl=0010, rd=3, WB=1 -> next cycle alu_result_o=12, zero_o=0, rd_addr_o=3, WB_o=1, stall_o never high.
REQ-034 SHALL cover sub wrap and zero: 0-1 with 0110 -> alu_result_o=0xFFFFFFFF; then 9-9 -> alu_result_o=0, zero_o=1.
REQ-035 SHALL cover mul: 0x0000FFFF x 0x00010001 with ALUCtrl=0011 held -> stall_o high for exactly 33 cycles, bubbles throughout, then alu_result_o=0xFFFFFFFF.
REQ-036 SHALL cover signed-wrap mul: 0xFFFFFFFF x 3 -> alu_result_o=0xFFFFFFFD.
REQ-037 SHALL cover flush mid-mul: flush_i=1 at counter=10 -> next cycle bubble, stall_o low; an and/or presented next completes in 1 cycle.
REQ-038 SHALL cover reset mid-mul: rst_i=1 at counter=20 -> all outputs 0, IDLE, stall_o=0, and the aborted product never appears.
